// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam logic [3:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  // Index of the lowest-numbered zero bit; 0 when no bit is low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: tick is high for the single cycle in which the
// counter sits at SCAN_PERIOD-1.
module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD = 131072
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/keypad_scan_cntr.sv
// Column-scanning keypad controller: walks a low column across the matrix,
// debounces the first key it finds and reports its code until released.
module keypad_scan_cntr
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD    = 131072,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_value,
  output logic             key_valid,
  output logic             key_pressed
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE_TICKS);

  logic              tick;
  logic [3:0]        row_meta;
  logic [3:0]        row_sync;
  scan_state_t       state;
  logic [1:0]        row_idx;
  logic [1:0]        col_idx;
  logic [DB_W-1:0]   match_cnt;
  logic [DB_W-1:0]   rel_cnt;
  logic [DB_W-1:0]   match_next;
  logic [DB_W-1:0]   rel_next;
  logic              row_hit;
  logic [3:0]        col_rot;

  keypad_tick_gen #(
    .SCAN_PERIOD(SCAN_PERIOD)
  ) u_tick_gen (
    .clk    (clk),
    .reset_p(reset_p),
    .tick   (tick)
  );

  // Synchronizer idles at "no row pulled low" so reset never looks like a press.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign row_hit    = ~row_sync[row_idx];
  assign col_rot    = {col[2:0], col[3]};
  assign match_next = (match_cnt == DB_DONE) ? match_cnt : match_cnt + 1'b1;
  assign rel_next   = (rel_cnt == DB_DONE) ? rel_cnt : rel_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state       <= SCAN;
      col         <= COL_RESET;
      row_idx     <= 2'd0;
      col_idx     <= 2'd0;
      match_cnt   <= '0;
      rel_cnt     <= '0;
      key_value   <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (row_sync != 4'hF) begin
              row_idx   <= low_index(row_sync);
              col_idx   <= low_index(col);
              match_cnt <= DB_W'(1);
              if (DEBOUNCE_TICKS == 1) begin
                key_value   <= {low_index(row_sync), low_index(col)};
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
                rel_cnt     <= '0;
                state       <= HELD;
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              col <= col_rot;
            end
          end
          DEBOUNCE: begin
            if (row_hit) begin
              match_cnt <= match_next;
              if (match_next == DB_DONE) begin
                key_value   <= {row_idx, col_idx};
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
                rel_cnt     <= '0;
                state       <= HELD;
              end
            end else begin
              state <= SCAN;
              col   <= col_rot;
            end
          end
          HELD: begin
            // Any low sample restarts the release count, so glitches extend the hold.
            if (row_hit) begin
              rel_cnt <= '0;
            end else begin
              rel_cnt <= rel_next;
              if (rel_next == DB_DONE) begin
                key_pressed <= 1'b0;
                state       <= SCAN;
                col         <= col_rot;
              end
            end
          end
          default: begin
            state <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_cntr.sv
// Bench for keypad_scan_cntr: a keypad matrix model drives row from col, and a
// tick-level reference model predicts col and the key outputs after every tick.
module tb_keypad_scan_cntr;
  import keypad_pkg::*;

  localparam int SP = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;

  int m_col, m_r, m_c, m_cnt, m_rel, tick_no;
  bit m_lock, m_acc;
  logic [3:0] exp_col, exp_value;
  logic       exp_valid, exp_pressed;
  logic       mid_bad;

  always #5 clk = ~clk;

  keypad_scan_cntr #(
    .SCAN_PERIOD   (SP),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .row        (row),
    .col        (col),
    .key_value  (key_value),
    .key_valid  (key_valid),
    .key_pressed(key_pressed)
  );

  // Matrix: key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  function automatic void model_reset();
    m_col = 0; m_r = 0; m_c = 0; m_cnt = 0; m_rel = 0;
    m_lock = 0; m_acc = 0;
    exp_col = 4'b1110; exp_value = 4'd0; exp_valid = 1'b0; exp_pressed = 1'b0;
  endfunction

  function automatic void model_accept();
    exp_valid   = 1'b1;
    exp_pressed = 1'b1;
    exp_value   = 4'(m_r * 4 + m_c);
    m_acc       = 1;
    m_rel       = 0;
  endfunction

  // One scan step: k is the set of keys held down during that column period.
  function automatic void model_tick(input logic [15:0] k);
    int found;
    exp_valid = 1'b0;
    if (!m_lock) begin
      found = -1;
      for (int r = 3; r >= 0; r--) if (k[r*4+m_col]) found = r;
      if (found >= 0) begin
        m_lock = 1; m_r = found; m_c = m_col; m_cnt = 1;
        if (m_cnt == DT) model_accept();
      end else begin
        m_col = (m_col + 1) % 4;
      end
    end else if (!m_acc) begin
      if (k[m_r*4+m_c]) begin
        m_cnt++;
        if (m_cnt == DT) model_accept();
      end else begin
        m_lock = 0;
        m_col  = (m_col + 1) % 4;
      end
    end else begin
      if (k[m_r*4+m_c]) begin
        m_rel = 0;
      end else begin
        m_rel++;
        if (m_rel == DT) begin
          exp_pressed = 1'b0;
          m_lock = 0; m_acc = 0;
          m_col = (m_col + 1) % 4;
        end
      end
    end
    exp_col = ~(4'b0001 << m_col);
  endfunction

  // Entered at the negedge just after a tick; leaves at the negedge after the next tick.
  task automatic step_tick(input logic [15:0] k);
    keys    = k;
    mid_bad = 1'b0;
    repeat (SP - 1) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid !== 1'b0 || col !== exp_col) mid_bad = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    model_tick(k);
    tick_no++;
  endtask

  task automatic test_reset();
    n_checks++;
    if (col !== 4'b1110) begin n_fail++; $display("[TB] FAIL reset_col: got %b want 1110", col); end
    n_checks++;
    if (key_value !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_value: got %0d want 0", key_value); end
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", key_valid); end
    n_checks++;
    if (key_pressed !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pressed: got %b want 0", key_pressed); end
    reset_p = 1'b0;
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 8; i++) begin
      step_tick(16'h0000);
      n_checks++;
      if (mid_bad !== 1'b0 || col !== exp_col || key_valid !== 1'b0 || key_pressed !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL idle_scan tick %0d: col=%b valid=%b pressed=%b mid_bad=%b, want col=%b valid=0 pressed=0 mid_bad=0",
                 tick_no, col, key_valid, key_pressed, mid_bad, exp_col);
      end
    end
  endtask

  task automatic test_press_release();
    logic [15:0] q[$];
    int pos;
    pos = (1 - m_col + 4) % 4;
    repeat (pos) q.push_back(16'h0000);
    repeat (5) q.push_back(16'h0200);
    repeat (4) q.push_back(16'h0000);
    foreach (q[i]) begin
      step_tick(q[i]);
      n_checks++;
      if (mid_bad !== 1'b0 || col !== exp_col || key_valid !== exp_valid || key_pressed !== exp_pressed || key_value !== exp_value) begin
        n_fail++;
        $display("[TB] FAIL press_release tick %0d: col=%b valid=%b pressed=%b value=%0d mid_bad=%b, want col=%b valid=%b pressed=%b value=%0d mid_bad=0",
                 tick_no, col, key_valid, key_pressed, key_value, mid_bad, exp_col, exp_valid, exp_pressed, exp_value);
      end
      if (i == pos + 2) begin
        n_checks++;
        if (key_valid !== 1'b1 || key_value !== 4'd9 || col !== 4'b1101) begin
          n_fail++;
          $display("[TB] FAIL press_code_9: valid=%b value=%0d col=%b, want valid=1 value=9 col=1101", key_valid, key_value, col);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] q[$];
    int pos;
    pos = (2 - m_col + 4) % 4;
    repeat (pos) q.push_back(16'h0000);
    q.push_back(16'h0040);
    repeat (3) q.push_back(16'h0000);
    foreach (q[i]) begin
      step_tick(q[i]);
      n_checks++;
      if (mid_bad !== 1'b0 || col !== exp_col || key_valid !== 1'b0 || key_pressed !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bounce tick %0d: col=%b valid=%b pressed=%b mid_bad=%b, want col=%b valid=0 pressed=0 mid_bad=0",
                 tick_no, col, key_valid, key_pressed, mid_bad, exp_col);
      end
    end
  endtask

  task automatic test_two_rows();
    logic [15:0] q[$];
    int pos, strobes;
    strobes = 0;
    pos = (3 - m_col + 4) % 4;
    repeat (pos) q.push_back(16'h0000);
    repeat (5) q.push_back(16'h0088);
    repeat (4) q.push_back(16'h0000);
    foreach (q[i]) begin
      step_tick(q[i]);
      if (key_valid === 1'b1) strobes++;
      n_checks++;
      if (mid_bad !== 1'b0 || col !== exp_col || key_valid !== exp_valid || key_pressed !== exp_pressed || key_value !== exp_value) begin
        n_fail++;
        $display("[TB] FAIL two_rows tick %0d: col=%b valid=%b pressed=%b value=%0d mid_bad=%b, want col=%b valid=%b pressed=%b value=%0d mid_bad=0",
                 tick_no, col, key_valid, key_pressed, key_value, mid_bad, exp_col, exp_valid, exp_pressed, exp_value);
      end
    end
    n_checks++;
    if (strobes != 1 || key_value !== 4'd3) begin
      n_fail++;
      $display("[TB] FAIL two_rows_code: strobes=%0d value=%0d, want strobes=1 value=3", strobes, key_value);
    end
  endtask

  task automatic test_reset_mid(input bit in_held);
    logic [15:0] q[$];
    int pos;
    pos = (0 - m_col + 4) % 4;
    repeat (pos) q.push_back(16'h0000);
    repeat (in_held ? 4 : 2) q.push_back(16'h0010);
    foreach (q[i]) step_tick(q[i]);
    #2 reset_p = 1'b1;
    #1;
    n_checks++;
    if (col !== 4'b1110 || key_valid !== 1'b0 || key_pressed !== 1'b0 || key_value !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid(held=%0d): col=%b valid=%b pressed=%b value=%0d, want 1110/0/0/0",
               in_held, col, key_valid, key_pressed, key_value);
    end
    model_reset();
    @(negedge clk);
    reset_p = 1'b0;
    q.delete();
    repeat (4) q.push_back(16'h0010);
    repeat (4) q.push_back(16'h0000);
    foreach (q[i]) begin
      step_tick(q[i]);
      n_checks++;
      if (mid_bad !== 1'b0 || col !== exp_col || key_valid !== exp_valid || key_pressed !== exp_pressed || key_value !== exp_value) begin
        n_fail++;
        $display("[TB] FAIL after_reset tick %0d: col=%b valid=%b pressed=%b value=%0d mid_bad=%b, want col=%b valid=%b pressed=%b value=%0d mid_bad=0",
                 tick_no, col, key_valid, key_pressed, key_value, mid_bad, exp_col, exp_valid, exp_pressed, exp_value);
      end
    end
  endtask

  task automatic test_release_glitch();
    logic [15:0] q[$];
    int pos;
    pos = (1 - m_col + 4) % 4;
    repeat (pos) q.push_back(16'h0000);
    repeat (4) q.push_back(16'h2000);
    q.push_back(16'h0000);
    q.push_back(16'h2000);
    repeat (4) q.push_back(16'h0000);
    foreach (q[i]) begin
      step_tick(q[i]);
      n_checks++;
      if (mid_bad !== 1'b0 || col !== exp_col || key_valid !== exp_valid || key_pressed !== exp_pressed || key_value !== exp_value) begin
        n_fail++;
        $display("[TB] FAIL release_glitch tick %0d: col=%b valid=%b pressed=%b value=%0d mid_bad=%b, want col=%b valid=%b pressed=%b value=%0d mid_bad=0",
                 tick_no, col, key_valid, key_pressed, key_value, mid_bad, exp_col, exp_valid, exp_pressed, exp_value);
      end
      if (i == pos + 7) begin
        n_checks++;
        if (key_pressed !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL glitch_hold: pressed=%b after two high ticks, want 1", key_pressed);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int sel, hold;
    for (int b = 0; b < 50; b++) begin
      sel = $urandom_range(0, 9);
      k   = '0;
      if (sel >= 8) k = 16'($urandom);
      else if (sel >= 4) k[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 7);
      repeat (hold) begin
        step_tick(k);
        n_checks++;
        if (mid_bad !== 1'b0 || col !== exp_col || key_valid !== exp_valid || key_pressed !== exp_pressed || key_value !== exp_value) begin
          n_fail++;
          $display("[TB] FAIL random tick %0d keys=%h: col=%b valid=%b pressed=%b value=%0d mid_bad=%b, want col=%b valid=%b pressed=%b value=%0d mid_bad=0",
                   tick_no, k, col, key_valid, key_pressed, key_value, mid_bad, exp_col, exp_valid, exp_pressed, exp_value);
        end
      end
    end
  endtask

  initial begin
    reset_p = 1'b1;
    keys    = 16'h0000;
    tick_no = 0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_idle_scan();
    test_press_release();
    test_bounce();
    test_two_rows();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_release_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
